tohost_monitor: RTL and testbench

- Sits between the core's `tohost` output and the seven-segment display driver. All logic runs in the core clock domain.
- Watches `tohost` for the test-completion write, filters transient values, and latches a sticky pass/fail result.
- Counts core cycles from reset release until the write.
- Drives the display word, alternating between the latched result and the cycle count.

---
 rtl/tohost_monitor_pkg.sv | 22 ++
 rtl/period_toggle.sv | 48 ++++
 rtl/tohost_monitor.sv | 121 ++++++++++++
 tb/tb_tohost_monitor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tohost_monitor_pkg.sv
// Shared definitions for the tohost completion monitor.
// Holds the monitor state encoding and the default constants used by
// tohost_monitor and its display-phase timer period_toggle.
package tohost_monitor_pkg;

   // RUN: counting cycles, SETTLE: filtering a candidate, DONE: result latched
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } mon_state_t;

   // tohost value that means the test passed
   localparam logic [31:0] PASS_CODE_DEFAULT = 32'h0000_0001;

   // cycle counter sticks here instead of wrapping
   localparam logic [31:0] CYCLES_SAT = 32'hFFFF_FFFF;

   // two seconds per display phase at 25 MHz
   localparam int unsigned TOGGLE_CYCLES_DEFAULT = 50_000_000;

endpackage

// File: rtl/period_toggle.sv
// Display phase timer for the tohost monitor.
// While enabled, counts PERIOD clocks per phase and flips show_o at the end
// of each phase. While disabled, or in reset, it sits at count 0, show_o 0,
// so every enable starts with a full phase of show_o=0.
// Ports:
//    clk_i   core clock
//    rst_i   asynchronous active-high reset
//    en_i    count enable (monitor is in DONE)
//    show_o  current phase, 1 = cycle count is on the display
module period_toggle
   import tohost_monitor_pkg::*;
#(
   parameter int unsigned PERIOD = TOGGLE_CYCLES_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic show_o
);

   // PERIOD of 1 still needs a one-bit counter that stays at 0
   localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [TW-1:0] TLAST = TW'(PERIOD - 1);
   localparam logic [TW-1:0] TONE = TW'(1);

   logic [TW-1:0] tcnt_q;
   logic          show_q;

   // Phase counter: clears whenever the monitor is not in DONE, then wraps
   // at PERIOD-1 and flips the phase on each wrap
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tcnt_q <= '0;
         show_q <= 1'b0;
      end else if (!en_i) begin
         tcnt_q <= '0;
         show_q <= 1'b0;
      end else if (tcnt_q == TLAST) begin
         tcnt_q <= '0;
         show_q <= ~show_q;
      end else begin
         tcnt_q <= tcnt_q + TONE;
      end
   end

   assign show_o = show_q;

endmodule

// File: rtl/tohost_monitor.sv
// Test-completion monitor between the core's tohost output and the
// seven-segment display driver.
// Counts core cycles from reset release until tohost goes nonzero, requires
// the nonzero value to be seen STABLE_CYCLES times in a row before accepting
// it, then latches the result until reset and alternates the display word
// between the result and the cycle count.
// Ports:
//    CLK          core clock
//    RST          asynchronous active-high reset
//    tohost       raw tohost word from the core
//    check        display word (0 until a result is latched)
//    done         result latched, sticky until reset
//    pass         done and result equals PASS_CODE
//    fail         done and result differs from PASS_CODE
//    test_num     result[31:1] on fail, else 0
//    show_cycles  1 while check shows the cycle count
module tohost_monitor
   import tohost_monitor_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned TOGGLE_CYCLES = TOGGLE_CYCLES_DEFAULT,
   parameter logic [31:0] PASS_CODE     = PASS_CODE_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] tohost,
   output logic [31:0] check,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic [30:0] test_num,
   output logic        show_cycles
);

   // scnt never needs to hold more than STABLE_CYCLES-1, but is set to 1
   localparam int unsigned SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [SW-1:0] SLAST = SW'(STABLE_CYCLES - 1);
   localparam logic [SW-1:0] SONE = SW'(1);

   mon_state_t    state_q;
   logic [31:0]   cycles_q;
   logic [31:0]   cycles_d;
   logic [31:0]   cand_q;
   logic [SW-1:0] scnt_q;
   logic [31:0]   result_q;
   logic          show_q;

   // Saturating increment so a hung test still shows all ones, not a wrapped value
   always_comb begin
      cycles_d = (cycles_q == CYCLES_SAT) ? cycles_q : cycles_q + 32'd1;
   end

   // Monitor FSM. Cycles only advance in RUN with tohost idle, so a rejected
   // glitch resumes the count from where it stopped. Any new nonzero value
   // restarts the stability count with that value as the candidate.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= RUN;
         cycles_q <= '0;
         cand_q   <= '0;
         scnt_q   <= '0;
         result_q <= '0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (tohost == 32'd0) begin
                  cycles_q <= cycles_d;
               end else begin
                  cand_q <= tohost;
                  scnt_q <= SONE;
                  if (STABLE_CYCLES == 1) begin
                     result_q <= tohost;
                     state_q  <= DONE;
                  end else begin
                     state_q <= SETTLE;
                  end
               end
            end
            SETTLE: begin
               if (tohost == cand_q) begin
                  if (scnt_q == SLAST) begin
                     result_q <= cand_q;
                     state_q  <= DONE;
                  end else begin
                     scnt_q <= scnt_q + SONE;
                  end
               end else if (tohost == 32'd0) begin
                  scnt_q  <= '0;
                  state_q <= RUN;
               end else begin
                  cand_q <= tohost;
                  scnt_q <= SONE;
               end
            end
            DONE: begin
            end
            default: begin
               state_q <= RUN;
            end
         endcase
      end
   end

   period_toggle #(
      .PERIOD (TOGGLE_CYCLES)
   ) u_toggle (
      .clk_i  (CLK),
      .rst_i  (RST),
      .en_i   (state_q == DONE),
      .show_o (show_q)
   );

   // Outputs are pure decode of registered state; tohost never reaches them directly
   assign done        = (state_q == DONE);
   assign pass        = done && (result_q == PASS_CODE);
   assign fail        = done && (result_q != PASS_CODE);
   assign test_num    = fail ? result_q[31:1] : 31'd0;
   assign show_cycles = show_q;
   assign check       = done ? (show_q ? cycles_q : result_q) : 32'd0;

endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor. Two instances share clock and reset: dut1 with
// a four-sample filter and dut2 with a single-sample filter, both with an
// eight-clock display phase. The stimulus process queues the completion it
// expects for each scenario; per-instance monitors pop an entry when done
// rises and then follow the display for two full phases.
module tb_tohost_monitor;

   typedef struct {
      int          doneEdge;
      logic [31:0] result;
      logic [31:0] cycles;
      logic        pass;
      logic        fail;
      logic [30:0] testNum;
   } expect_t;

   logic        CLK;
   logic        RST;
   logic [31:0] tohost1;
   logic [31:0] tohost2;
   logic [31:0] check1, check2;
   logic        done1, done2;
   logic        pass1, pass2;
   logic        fail1, fail2;
   logic [30:0] testNum1, testNum2;
   logic        show1, show2;

   int checks = 0;
   int failures = 0;
   int edgeNum = -1;

   expect_t exp1Q[$];
   expect_t exp2Q[$];

   tohost_monitor #(
      .STABLE_CYCLES (4),
      .TOGGLE_CYCLES (8),
      .PASS_CODE     (32'h1)
   ) dut1 (
      .CLK         (CLK),
      .RST         (RST),
      .tohost      (tohost1),
      .check       (check1),
      .done        (done1),
      .pass        (pass1),
      .fail        (fail1),
      .test_num    (testNum1),
      .show_cycles (show1)
   );

   tohost_monitor #(
      .STABLE_CYCLES (1),
      .TOGGLE_CYCLES (8),
      .PASS_CODE     (32'h1)
   ) dut2 (
      .CLK         (CLK),
      .RST         (RST),
      .tohost      (tohost2),
      .check       (check2),
      .done        (done2),
      .pass        (pass2),
      .fail        (fail2),
      .test_num    (testNum2),
      .show_cycles (show2)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Edge 0 is the first rising edge that sees reset released
   always @(posedge CLK) begin
      if (RST) edgeNum = -1;
      else     edgeNum = edgeNum + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   function automatic expect_t mkExp(input int e, input logic [31:0] r,
                                     input logic [31:0] c, input logic p,
                                     input logic f, input logic [30:0] t);
      expect_t x;
      x.doneEdge = e;
      x.result   = r;
      x.cycles   = c;
      x.pass     = p;
      x.fail     = f;
      x.testNum  = t;
      return x;
   endfunction

   // Holds tohost1 at value for count sampling edges, starting at a falling edge
   task automatic applyStimulus(input logic [31:0] value, input int count);
      for (int i = 0; i < count; i++) begin
         tohost1 = value;
         @(negedge CLK);
      end
   endtask

   // Asserts reset between edges, checks it acts without a clock, then releases
   task automatic doReset();
      #2 RST = 1'b1;
      #1;
      checkOutput("asyncReset done", {31'd0, done1}, 32'd0);
      checkOutput("asyncReset check", check1, 32'd0);
      checkOutput("asyncReset show", {31'd0, show1}, 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // dut1 monitor
   expect_t cur1;
   bit      inDone1 = 0;
   bit      haveCur1 = 0;
   int      disp1 = 0;
   always @(negedge CLK) begin
      if (RST) begin
         inDone1 = 0;
      end else begin
         if (done1 && !inDone1) begin
            inDone1 = 1;
            disp1 = 0;
            if (exp1Q.size() == 0) begin
               haveCur1 = 0;
               checks++;
               failures++;
               $display("[TB] FAIL dut1 unexpectedDone actual=1 expected=0 at edge %0d", edgeNum);
            end else begin
               cur1 = exp1Q.pop_front();
               haveCur1 = 1;
               checkOutput("dut1 doneEdge", 32'(edgeNum), 32'(cur1.doneEdge));
               checkOutput("dut1 pass", {31'd0, pass1}, {31'd0, cur1.pass});
               checkOutput("dut1 fail", {31'd0, fail1}, {31'd0, cur1.fail});
               checkOutput("dut1 test_num", {1'b0, testNum1}, {1'b0, cur1.testNum});
            end
         end
         if (inDone1 && haveCur1 && disp1 < 16) begin
            checkOutput("dut1 displayDone", {31'd0, done1}, 32'd1);
            checkOutput("dut1 show_cycles", {31'd0, show1}, (disp1 >= 8) ? 32'd1 : 32'd0);
            checkOutput("dut1 check", check1, (disp1 >= 8) ? cur1.cycles : cur1.result);
            disp1++;
         end
      end
   end

   // dut2 monitor
   expect_t cur2;
   bit      inDone2 = 0;
   bit      haveCur2 = 0;
   int      disp2 = 0;
   always @(negedge CLK) begin
      if (RST) begin
         inDone2 = 0;
      end else begin
         if (done2 && !inDone2) begin
            inDone2 = 1;
            disp2 = 0;
            if (exp2Q.size() == 0) begin
               haveCur2 = 0;
               checks++;
               failures++;
               $display("[TB] FAIL dut2 unexpectedDone actual=1 expected=0 at edge %0d", edgeNum);
            end else begin
               cur2 = exp2Q.pop_front();
               haveCur2 = 1;
               checkOutput("dut2 doneEdge", 32'(edgeNum), 32'(cur2.doneEdge));
               checkOutput("dut2 pass", {31'd0, pass2}, {31'd0, cur2.pass});
               checkOutput("dut2 fail", {31'd0, fail2}, {31'd0, cur2.fail});
            end
         end
         if (inDone2 && haveCur2 && disp2 < 16) begin
            checkOutput("dut2 check", check2, (disp2 >= 8) ? cur2.cycles : cur2.result);
            disp2++;
         end
      end
   end

   initial begin
      RST = 1'b1;
      tohost1 = 32'd0;
      tohost2 = 32'd0;
      @(negedge CLK);
      $display("[TB] reset values");
      checkOutput("reset check", check1, 32'd0);
      checkOutput("reset done", {31'd0, done1}, 32'd0);
      checkOutput("reset pass", {31'd0, pass1}, 32'd0);
      checkOutput("reset fail", {31'd0, fail1}, 32'd0);
      checkOutput("reset test_num", {1'b0, testNum1}, 32'd0);
      checkOutput("reset show_cycles", {31'd0, show1}, 32'd0);
      checkOutput("reset dut2 done", {31'd0, done2}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      // Pass: 100 idle edges, 1 from edge 100, accepted at edge 103.
      // tohost then changes to 0 and 2 during DONE without effect.
      $display("[TB] pass path and sticky result");
      applyStimulus(32'd0, 100);
      exp1Q.push_back(mkExp(103, 32'h1, 32'd100, 1'b1, 1'b0, 31'd0));
      applyStimulus(32'd1, 8);
      applyStimulus(32'd0, 8);
      applyStimulus(32'd2, 8);
      checkOutput("sticky done", {31'd0, done1}, 32'd1);
      checkOutput("sticky pass", {31'd0, pass1}, 32'd1);

      // Reset out of DONE; the next run counts from 0 again.
      // Fail: 50 idle edges, 7 from edge 50, accepted at edge 53, test 3.
      doReset();
      $display("[TB] fail path after reset");
      applyStimulus(32'd0, 50);
      exp1Q.push_back(mkExp(53, 32'h7, 32'd50, 1'b0, 1'b1, 31'd3));
      applyStimulus(32'd7, 24);

      // Glitch: 30 idle, 5 at edges 30-31, 0 at edge 32 returns to RUN
      // without counting, edges 33-51 count to 49. Then 9 from edge 52.
      doReset();
      $display("[TB] glitch filter");
      applyStimulus(32'd0, 30);
      applyStimulus(32'd5, 2);
      applyStimulus(32'd0, 20);
      checkOutput("glitch done", {31'd0, done1}, 32'd0);
      checkOutput("glitch check", check1, 32'd0);
      exp1Q.push_back(mkExp(55, 32'h9, 32'd49, 1'b0, 1'b1, 31'd4));
      applyStimulus(32'd9, 24);

      // Value change in SETTLE: 20 idle, 3 at edges 20-21, 1 from edge 22,
      // 4th sample of 1 at edge 25. dut2 sees 1 first at edge 10.
      doReset();
      $display("[TB] candidate change and single-sample filter");
      applyStimulus(32'd0, 10);
      tohost2 = 32'd1;
      exp2Q.push_back(mkExp(10, 32'h1, 32'd10, 1'b1, 1'b0, 31'd0));
      applyStimulus(32'd0, 10);
      applyStimulus(32'd3, 2);
      exp1Q.push_back(mkExp(25, 32'h1, 32'd20, 1'b1, 1'b0, 31'd0));
      applyStimulus(32'd1, 24);

      checkOutput("pending dut1 completions", 32'(exp1Q.size()), 32'd0);
      checkOutput("pending dut2 completions", 32'(exp2Q.size()), 32'd0);
      checkOutput("dut1 display windows", 32'(disp1), 32'd16);
      checkOutput("dut2 display windows", 32'(disp2), 32'd16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
